// File: rtl/mem_pkg.sv
// Shared memory-op encodings, FSM state encoding and lane helpers for the
// memory-access stage and any other data-bus client (e.g. the cache path).
package mem_pkg;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LB   = 4'd1;
    localparam logic [3:0] OP_LBU  = 4'd2;
    localparam logic [3:0] OP_LH   = 4'd3;
    localparam logic [3:0] OP_LHU  = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SB   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] wdata;
    } store_lanes_t;

    // Unassigned codes behave exactly like NONE.
    function automatic logic [3:0] op_norm(input logic [3:0] op);
        return (op > OP_SW) ? OP_NONE : op;
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_LW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] lane);
        logic half;
        logic word;
        half = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
        word = (op == OP_LW) || (op == OP_SW);
        return (half && lane[0]) || (word && (lane != 2'b00));
    endfunction

    function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] lane,
                                                 input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {lane, 3'b000};
        case (op)
            OP_LB:   res = {{24{sh[7]}}, sh[7:0]};
            OP_LBU:  res = {24'h0, sh[7:0]};
            OP_LH:   res = {{16{sh[15]}}, sh[15:0]};
            OP_LHU:  res = {16'h0, sh[15:0]};
            OP_LW:   res = word;
            default: res = 32'h0;
        endcase
        return res;
    endfunction

    function automatic store_lanes_t store_lanes(input logic [3:0] op, input logic [1:0] lane,
                                                 input logic [31:0] data);
        store_lanes_t sl;
        case (op)
            OP_SB: begin
                sl.be    = 4'b0001 << lane;
                sl.wdata = {4{data[7:0]}};
            end
            OP_SH: begin
                sl.be    = lane[1] ? 4'b1100 : 4'b0011;
                sl.wdata = {2{data[15:0]}};
            end
            OP_SW: begin
                sl.be    = 4'b1111;
                sl.wdata = data;
            end
            default: begin
                sl.be    = 4'b0000;
                sl.wdata = 32'h0;
            end
        endcase
        return sl;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering: store byte-enables/replicated data and
// load-data extraction with sign/zero extension.
module mem_align
    import mem_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  lane,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    store_lanes_t sl;

    assign sl        = store_lanes(op, lane, store_data);
    assign be        = sl.be;
    assign wdata     = sl.wdata;
    assign load_data = load_extract(op, lane, load_word);

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access pipeline stage: one instruction at a time from execute,
// req/ack data-bus access with flush draining, registered write-back slot.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int PC_W   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,

    input  logic              exe_valid,
    output logic              exe_ready,
    input  logic [PC_W-1:0]   exe_pc,
    input  logic [31:0]       exe_inst,
    input  logic [31:0]       exe_result,
    input  logic [31:0]       exe_store_data,
    input  logic [3:0]        exe_mem_op,
    input  logic [REG_AW-1:0] exe_write_reg,
    input  logic              exe_reg_write,

    output logic              data_req,
    output logic              data_wr,
    output logic [3:0]        data_be,
    output logic [ADDR_W-1:0] data_addr,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata,

    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [PC_W-1:0]   wb_pc,
    output logic [31:0]       wb_inst,
    output logic [31:0]       wb_result,
    output logic [REG_AW-1:0] wb_write_reg,
    output logic              wb_reg_write,
    output logic              wb_adel,
    output logic              wb_ades,
    output logic [31:0]       wb_badvaddr
);

    logic [1:0]        state;
    logic [1:0]        state_d;

    logic [3:0]        op_q;
    logic [1:0]        lane_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       sdata_q;
    logic [PC_W-1:0]   pc_q;
    logic [31:0]       inst_q;
    logic [31:0]       result_q;
    logic [REG_AW-1:0] wreg_q;
    logic              regw_q;

    logic [3:0]        op_in;
    logic              mis_in;
    logic              bus_op_in;
    logic              accept;
    logic              go_bus;
    logic              direct;
    logic              bus_done;

    logic [3:0]        al_be;
    logic [31:0]       al_wdata;
    logic [31:0]       al_load;

    assign op_in     = op_norm(exe_mem_op);
    assign mis_in    = misaligned(op_in, exe_result[1:0]);
    assign bus_op_in = (op_in != OP_NONE) && !mis_in;

    // Gated by rstn so every output reads 0 while reset is held.
    assign exe_ready = rstn && (state == ST_IDLE) && (!wb_valid || wb_ready) && !flush;
    assign accept    = exe_valid && exe_ready;
    assign go_bus    = accept && bus_op_in;
    assign direct    = accept && !bus_op_in;
    assign bus_done  = (state == ST_WAIT) && data_data_ok && !flush;

    mem_align u_align (
        .op         (op_q),
        .lane       (lane_q),
        .store_data (sdata_q),
        .load_word  (data_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_data  (al_load)
    );

    assign data_req   = (state == ST_REQ);
    assign data_wr    = data_req && is_store(op_q);
    assign data_be    = data_req ? al_be : 4'b0000;
    assign data_addr  = data_req ? addr_q : '0;
    assign data_wdata = data_req ? al_wdata : 32'h0;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: begin
                if (go_bus) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (flush)             state_d = data_addr_ok ? ST_DRAIN : ST_IDLE;
                else if (data_addr_ok) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A response coinciding with flush completes the transfer;
                // it is discarded and there is nothing left to drain.
                if (data_data_ok) state_d = ST_IDLE;
                else if (flush)   state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (data_data_ok) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from pre-edge values, independent of block order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            op_q     <= OP_NONE;
            lane_q   <= 2'b00;
            addr_q   <= '0;
            sdata_q  <= 32'h0;
            pc_q     <= '0;
            inst_q   <= 32'h0;
            result_q <= 32'h0;
            wreg_q   <= '0;
            regw_q   <= 1'b0;
        end else begin
            state <= state_d;
            if (go_bus) begin
                op_q     <= op_in;
                lane_q   <= exe_result[1:0];
                addr_q   <= {exe_result[ADDR_W-1:2], 2'b00};
                sdata_q  <= exe_store_data;
                pc_q     <= exe_pc;
                inst_q   <= exe_inst;
                result_q <= exe_result;
                wreg_q   <= exe_write_reg;
                regw_q   <= exe_reg_write;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wb_valid     <= 1'b0;
            wb_pc        <= '0;
            wb_inst      <= 32'h0;
            wb_result    <= 32'h0;
            wb_write_reg <= '0;
            wb_reg_write <= 1'b0;
            wb_adel      <= 1'b0;
            wb_ades      <= 1'b0;
            wb_badvaddr  <= 32'h0;
        end else begin
            if (flush)                        wb_valid <= 1'b0;
            else if (direct || bus_done)      wb_valid <= 1'b1;
            else if (wb_ready)                wb_valid <= 1'b0;

            if (direct) begin
                wb_pc        <= exe_pc;
                wb_inst      <= exe_inst;
                wb_result    <= exe_result;
                wb_write_reg <= exe_write_reg;
                wb_reg_write <= exe_reg_write && !mis_in;
                wb_adel      <= mis_in && is_load(op_in);
                wb_ades      <= mis_in && is_store(op_in);
                wb_badvaddr  <= mis_in ? exe_result : 32'h0;
            end else if (bus_done) begin
                wb_pc        <= pc_q;
                wb_inst      <= inst_q;
                wb_result    <= is_store(op_q) ? result_q : al_load;
                wb_write_reg <= wreg_q;
                wb_reg_write <= regw_q;
                wb_adel      <= 1'b0;
                wb_ades      <= 1'b0;
                wb_badvaddr  <= 32'h0;
            end
        end
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised memory-access pipeline stage between execute and write-back. Accepts one instruction per handshake from execute, performs byte/half/word loads and stores over a request/acknowledge data-bus with arbitrary wait states, aligns and extends load data, and detects misaligned accesses. Its single registered output slot feeds write-back through a valid/ready handshake. The stage supports flush with correct draining of an outstanding bus transaction.

## Interface
Parameters:
- ADDR_W, 32, data-bus address width (≥ 2)
- PC_W, 32, pc width carried alongside the instruction
- REG_AW, 5, destination register index width

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- flush  in  1  discard the in-flight instruction and any held output
- exe_valid  in  1  execute offers an instruction
- exe_ready  out  1  stage accepts this cycle
- exe_pc  in  PC_W  instruction pc
- exe_inst  in  32  instruction word, passed through
- exe_result  in  32  ALU result; the effective address for memory ops
- exe_store_data  in  32  rt value for stores
- exe_mem_op  in  4  memory operation code, shared package
- exe_write_reg  in  REG_AW  destination register
- exe_reg_write  in  1  register write enable
- data_req  out  1  bus request
- data_wr  out  1  1 = store
- data_be  out  4  byte enables
- data_addr  out  ADDR_W  word-aligned address, low 2 bits zero
- data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response complete, earliest one cycle after addr_ok
- data_rdata  in  32  read word, valid with data_ok
- wb_valid  out  1  output slot full
- wb_ready  in  1  write-back consumes the slot
- wb_pc, wb_inst, wb_result, wb_write_reg, wb_reg_write  out  registered results
- wb_adel, wb_ades  out  1  load / store address error
- wb_badvaddr  out  32  faulting address, full exe_result

## Operation
- Op codes: NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8. Codes 9–15 are treated as NONE.
- States: IDLE, REQ, WAIT, DRAIN. Reset enters IDLE.
- exe_ready = (state==IDLE) & (!wb_valid | wb_ready) & !flush.
- Accept with NONE op, or with a misaligned access: the output slot loads directly.
  - Halfword ops are misaligned when addr[0]=1; word ops when addr[1:0]≠0.
  - Misaligned loads set wb_adel; misaligned stores set wb_ades. Either case forces wb_reg_write=0 and sets wb_badvaddr=addr.
  - No bus request is issued.
- Accept with an aligned memory op: latch the op, the lane (addr[1:0]) and the passthroughs, then go to REQ.
- REQ: data_req=1; address, be and wdata are held stable. On addr_ok go to WAIT.
- WAIT: on data_ok, load the slot and go to IDLE.
  - wb_result is the extracted load (LB/LH sign-extend, LBU/LHU zero-extend, LW whole word).
  - For stores, wb_result is exe_result.
- Store lanes:
  - SB: be = 1<<addr[1:0], wdata = {4{b}}.
  - SH: be = 4'b0011 or 4'b1100 by addr[1], wdata = {2{h}}.
  - SW: be = 4'b1111.
- Flush:
  - Clears wb_valid.
  - In REQ with addr_ok low: withdraw the request, go to IDLE.
  - In REQ with addr_ok high, or in WAIT: go to DRAIN.
  - DRAIN waits for data_ok, discards it, then goes to IDLE.
  - In IDLE: nothing further is done.
- Slot drains when wb_ready & wb_valid. wb_valid clears unless a new result loads in the same cycle.

## Timing
- Reset: every output 0, state IDLE; exe_ready is 1 once reset deasserts.
- NONE or misaligned op accepted in cycle N: wb_valid=1 in N+1.
- Aligned memory op accepted in N:
  - data_req high from N+1.
  - Best case is addr_ok in N+1 and data_ok in N+2, giving wb_valid in N+3.
  - Each bus wait cycle adds one cycle.
- Sustained NONE throughput: 1 per cycle while wb_ready=1. A held output (wb_ready=0) stalls execute with zero bubbles.
- data_ok arriving in the same cycle as flush is discarded.
- Reset mid-transaction drops everything; the bus must also reset.

## Structure
- Package mem_pkg: op-code localparams, state encoding, functions load_extract(op, lane, word) and store_lanes(op, lane, data).
- One sub-module, mem_align: the combinational store-lane and load-extract logic, reusable by the cache path.

## Test plan
- LW addr 0x100, addr_ok and data_ok after 2 waits each, rdata 0x89ABCDEF → wb_result 0x89ABCDEF, wb_valid at accept+7.
- LB addr 0x103, rdata 0x80FF1234 → 0xFFFFFF80; LBU → 0x00000080; LH addr 0x102 → 0xFFFF80FF.
- SH addr 0x202, data 0x0000BEEF → data_be 1100, data_wdata 0xBEEFBEEF, wb_reg_write passthrough.
- LW addr 0x101 → no data_req, wb_adel=1, wb_badvaddr 0x101, wb_reg_write=0 at N+1.
- Flush in WAIT, data_ok two cycles later → DRAIN, no wb_valid, next instruction accepted the cycle after data_ok.
- Back-to-back NONE ops with wb_ready toggling 1,0,1 → no lost or duplicated wb_pc values.
